// File: rtl/neuron_mac.sv
// Signed fixed-point dot-product neuron: streams N_INPUTS weight/feature pairs plus a bias word.
// Optional macro RELU_EN clamps negative results to zero in the DONE cycle.
module neuron_mac #(
    parameter int DATA_W    = 10,
    parameter int FRAC_BITS = 6,
    parameter int N_INPUTS  = 64,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = 28
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              start,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    state_t                     state, state_nxt;
    logic [ADDR_W-1:0]          addr;
    logic                       last_addr;
    logic                       d_vld, d_bias;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc, acc_nxt, shifted;
    logic signed [DATA_W-1:0]   sat_val, res_val;

    assign last_addr = (addr == ADDR_W'(N_INPUTS));
    assign w_addr    = addr;
    assign f_addr    = addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first keeps this combinational block from inferring latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Address counter stops at N_INPUTS, so it can never wrap.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)                          addr <= '0;
        else if (state == RUN && !last_addr) addr <= addr + ADDR_W'(1);
        else                              addr <= '0;
    end

    // Read data lags the address by one cycle; track which word is arriving.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            d_vld  <= 1'b0;
            d_bias <= 1'b0;
        end else begin
            d_vld  <= (state == RUN);
            d_bias <= (state == RUN) && last_addr;
        end
    end

    always_comb begin
        prod    = $signed(w_data) * $signed(f_data);
        acc_nxt = acc;
        if (d_vld) begin
            if (d_bias) acc_nxt = acc + (ACC_W'($signed(w_data)) <<< FRAC_BITS);
            else        acc_nxt = acc + ACC_W'(prod);
        end
    end

    // Saturate the final sum; the result register is loaded on entry to DONE.
    always_comb begin
        shifted = acc_nxt >>> FRAC_BITS;
        if (shifted > SAT_MAX)      sat_val = DATA_W'(SAT_MAX);
        else if (shifted < SAT_MIN) sat_val = DATA_W'(SAT_MIN);
        else                        sat_val = shifted[DATA_W-1:0];
`ifdef RELU_EN
        res_val = (sat_val < 0) ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)                acc <= '0;
        else if (state == IDLE) acc <= '0;
        else                    acc <= acc_nxt;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)                 result <= '0;
        else if (state == DRAIN) result <= res_val;
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: latency, saturation, bias, reset and start handling.
module tb_neuron_mac;

    logic       Clock = 1'b0;
    logic       Rst;
    logic       start;
    logic [6:0] w_addr, f_addr;
    logic [9:0] w_data, f_data;
    logic       busy, done;
    logic [9:0] result;

    logic [9:0] w_mem [128];
    logic [9:0] f_mem [128];

    int checks   = 0;
    int failures = 0;

    neuron_mac dut (
        .Clock (Clock),
        .Rst   (Rst),
        .start (start),
        .w_addr(w_addr),
        .w_data(w_data),
        .f_addr(f_addr),
        .f_data(f_data),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read RAM models: data valid one cycle after address.
    always @(posedge Clock) begin
        w_data <= w_mem[w_addr];
        f_data <= f_mem[f_addr];
    end

    task automatic fill(input logic [9:0] wv, input logic [9:0] fv, input int n,
                        input logic [9:0] bias);
        for (int i = 0; i < 128; i++) begin
            w_mem[i] = (i < n) ? wv : 10'd0;
            f_mem[i] = (i < n) ? fv : 10'd0;
        end
        w_mem[64] = bias;
        f_mem[64] = 10'h155;  // must be ignored at the bias slot
    endtask

    task automatic run(output int lat);
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic check_run(input string name, input logic [9:0] exp);
        int lat;
        run(lat);
        checks++;
        if (lat !== 67) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected 67", name, lat);
        end
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL %s_result: got %0d expected %0d", name, $signed(result), $signed(exp));
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1; start = 1'b0;
        fill(10'd0, 10'd0, 0, 10'd0);
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({busy, done, result, w_addr, f_addr} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%0d w_addr=%0d f_addr=%0d expected all 0",
                     busy, done, result, w_addr, f_addr);
        end
        Rst = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        fill(10'd32, 10'd64, 8, 10'd0);
        check_run("basic", 10'd256);
    endtask

    task automatic test_midrun_reset;
        int n;
        fill(10'd32, 10'd64, 8, 10'd0);
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        n = 0;
        while (w_addr !== 7'd20 && n < 100) begin
            @(posedge Clock); #1;
            n++;
        end
        checks++;
        if (w_addr !== 7'd20) begin
            failures++;
            $display("FAIL midrun_reach_addr20: got %0d expected 20", w_addr);
        end
        Rst = 1'b1;
        @(posedge Clock); #1;
        checks++;
        if ({busy, done, result, w_addr, f_addr} !== 26'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%0d w_addr=%0d f_addr=%0d expected all 0",
                     busy, done, result, w_addr, f_addr);
        end
        Rst = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_post_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_saturation;
        logic [9:0] exp_neg;
`ifdef RELU_EN
        exp_neg = 10'd0;
`else
        exp_neg = 10'h200;  // -512
`endif
        fill(10'd64, 10'd64, 64, 10'd0);
        check_run("pos_sat", 10'd511);
        fill(10'h3C0, 10'd64, 64, 10'd0);  // w = -64
        check_run("neg_sat", exp_neg);
    endtask

    task automatic test_bias;
        logic [9:0] exp_b;
`ifdef RELU_EN
        exp_b = 10'd0;
`else
        exp_b = 10'h3DB;  // -37
`endif
        fill(10'd0, 10'd0, 0, 10'h3DB);
        check_run("bias_only", exp_b);
    endtask

    task automatic test_start_ignored;
        int lat, first, ndone, busy_after;
        fill(10'd32, 10'd64, 8, 10'd0);
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        lat = 1; first = 0; ndone = 0; busy_after = 0;
        while (lat < 80) begin
            if (done) begin
                ndone++;
                if (first == 0) first = lat;
            end
            if (lat > 67 && busy) busy_after++;
            @(posedge Clock); #1;
            lat++;
            start = (lat == 10 || lat == 67);
        end
        start = 1'b0;
        checks++;
        if (first !== 67) begin
            failures++;
            $display("FAIL ignore_latency: got %0d expected 67", first);
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d expected 1", ndone);
        end
        checks++;
        if (busy_after !== 0) begin
            failures++;
            $display("FAIL ignore_restart: busy cycles after done %0d expected 0", busy_after);
        end
        checks++;
        if (result !== 10'd256) begin
            failures++;
            $display("FAIL ignore_result: got %0d expected 256", $signed(result));
        end
    endtask

    task automatic test_back_to_back;
        int cyc, d1, d2;
        fill(10'd0, 10'd0, 0, 10'd100);
        start = 1'b1;
        @(posedge Clock); #1;
        cyc = 1; d1 = 0; d2 = 0;
        while (d2 == 0 && cyc < 300) begin
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else         d2 = cyc;
            end
            if (d2 == 0) begin
                @(posedge Clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        checks++;
        if (d1 !== 67) begin
            failures++;
            $display("FAIL b2b_first_done: got %0d expected 67", d1);
        end
        checks++;
        if (d2 - d1 !== 68) begin
            failures++;
            $display("FAIL b2b_gap: got %0d expected 68", d2 - d1);
        end
        checks++;
        if (result !== 10'd100) begin
            failures++;
            $display("FAIL b2b_result: got %0d expected 100", $signed(result));
        end
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final_idle: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midrun_reset();
        test_saturation();
        test_bias();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
